// File: rtl/down_count_checker_if.sv
// Port bundle for down_count_checker: sampled count, qualifiers and monitor results.
// The master modport drives the count stream; the slave modport is the checker.
interface down_count_checker_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
);
    logic [WIDTH-1:0]  cnt_in;
    logic              cnt_valid;
    logic              err_clr;
    logic              locked;
    logic              wrap_pulse;
    logic              err_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;
    logic              err_sticky;

    modport master (
        output cnt_in, cnt_valid, err_clr,
        input  locked, wrap_pulse, err_pulse, wrap_count, err_count, err_sticky
    );

    modport slave (
        input  cnt_in, cnt_valid, err_clr,
        output locked, wrap_pulse, err_pulse, wrap_count, err_count, err_sticky
    );
endinterface

// File: rtl/down_count_checker.sv
// Self-check monitor for a down counter: verifies each valid sample is prev-1 (mod 2^WIDTH),
// tracks lock, and counts wraps/errors. Optional sticky error flag under `ifdef STICKY_ERR_EN.
module down_count_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8
) (
    input logic                  clk,
    input logic                  rst,
    down_count_checker_if.slave  bus
);
    localparam int RUN_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] LOCK_VAL = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACK    = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  prev_reg;
    logic [RUN_W-1:0]  run_reg;
    logic              locked_reg;
    logic              wrap_pulse_reg;
    logic              err_pulse_reg;
    logic [WRAP_W-1:0] wrap_count_reg;
    logic [ERR_W-1:0]  err_count_reg;

    logic [WIDTH-1:0]  prev_dec;
    logic [RUN_W-1:0]  run_next;
    logic              step_ok;
    logic              err_now;
    logic              wrap_now;

    always_comb begin
        prev_dec = prev_reg - WIDTH'(1);
        run_next = run_reg + RUN_W'(1);
        step_ok  = bus.cnt_valid && (bus.cnt_in == prev_dec);
        err_now  = bus.cnt_valid && (state_reg == LOCKED) && (bus.cnt_in != prev_dec);
        // The ok test already implies cnt_in is all-ones when prev is zero.
        wrap_now = step_ok && (state_reg != UNLOCKED) && (prev_reg == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= UNLOCKED;
            prev_reg       <= '0;
            run_reg        <= '0;
            locked_reg     <= 1'b0;
            wrap_pulse_reg <= 1'b0;
            err_pulse_reg  <= 1'b0;
            wrap_count_reg <= '0;
            err_count_reg  <= '0;
        end else begin
            wrap_pulse_reg <= wrap_now;
            err_pulse_reg  <= err_now;
            if (wrap_now && (wrap_count_reg != '1))
                wrap_count_reg <= wrap_count_reg + WRAP_W'(1);
            if (err_now && (err_count_reg != '1))
                err_count_reg <= err_count_reg + ERR_W'(1);

            if (bus.cnt_valid) begin
                prev_reg <= bus.cnt_in;
                case (state_reg)
                    UNLOCKED: begin
                        run_reg   <= '0;
                        state_reg <= TRACK;
                    end
                    TRACK: begin
                        if (step_ok) begin
                            run_reg <= run_next;
                            if (run_next == LOCK_VAL) begin
                                state_reg  <= LOCKED;
                                locked_reg <= 1'b1;
                            end
                        end else begin
                            run_reg <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!step_ok) begin
                            run_reg    <= '0;
                            state_reg  <= TRACK;
                            locked_reg <= 1'b0;
                        end
                    end
                    default: begin
                        run_reg    <= '0;
                        state_reg  <= UNLOCKED;
                        locked_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STICKY_ERR_EN
    logic err_sticky_reg;

    // A new error on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst)
            err_sticky_reg <= 1'b0;
        else if (err_now)
            err_sticky_reg <= 1'b1;
        else if (bus.err_clr)
            err_sticky_reg <= 1'b0;
    end

    assign bus.err_sticky = err_sticky_reg;
`else
    wire unused_err_clr = bus.err_clr;
    assign bus.err_sticky = 1'b0;
`endif

    assign bus.locked     = locked_reg;
    assign bus.wrap_pulse = wrap_pulse_reg;
    assign bus.err_pulse  = err_pulse_reg;
    assign bus.wrap_count = wrap_count_reg;
    assign bus.err_count  = err_count_reg;
endmodule
